ptr_prefetch: RTL

PTR_PREFETCH -- requirements
Module: ptr_prefetch

---
 rtl/ptr_prefetch_if.sv | 29 ++
 rtl/ptr_prefetch.sv | 120 ++++++++++++
 2 files changed

// File: rtl/ptr_prefetch_if.sv
// Bundle of free-list read signals and consumer allocation signals for ptr_prefetch.
// The master view is the prefetcher; the slave view is the free list plus consumer.
interface ptr_prefetch_if #(
    parameter int DATA_WIDTH     = 10,
    parameter int PREFETCH_DEPTH = 4
) ();
    localparam int LVL_W = $clog2(PREFETCH_DEPTH) + 1;

    logic                  fl_init_done;
    logic                  fl_empty;
    logic                  fl_rd_req;
    logic [DATA_WIDTH-1:0] fl_rd_dout;
    logic                  alloc_valid;
    logic [DATA_WIDTH-1:0] alloc_ptr;
    logic                  alloc_req;
    logic [LVL_W-1:0]      alloc_level;
    logic [31:0]           alloc_total;
    logic                  alloc_underflow;

    modport master (
        input  fl_init_done, fl_empty, fl_rd_dout, alloc_req,
        output fl_rd_req, alloc_valid, alloc_ptr, alloc_level, alloc_total, alloc_underflow
    );

    modport slave (
        output fl_init_done, fl_empty, fl_rd_dout, alloc_req,
        input  fl_rd_req, alloc_valid, alloc_ptr, alloc_level, alloc_total, alloc_underflow
    );
endinterface

// File: rtl/ptr_prefetch.sv
// Pointer prefetcher: keeps a small show-ahead FIFO of free-list pointers topped up
// so a consumer can allocate one pointer per cycle despite the free-list read latency.
module ptr_prefetch #(
    parameter int DATA_WIDTH     = 10,
    parameter int PREFETCH_DEPTH = 4,
    parameter int RD_LATENCY     = 2
) (
    input  logic           clk,
    input  logic           rstn,
    ptr_prefetch_if.master bus
);
    localparam int ADDR_W = $clog2(PREFETCH_DEPTH);
    localparam int LVL_W  = $clog2(PREFETCH_DEPTH) + 1;

    typedef enum logic {
        WAIT_INIT = 1'b0,
        RUN       = 1'b1
    } state_t;

    state_t                state;
    state_t                next_state;
    logic [DATA_WIDTH-1:0] mem [PREFETCH_DEPTH];
    logic [ADDR_W-1:0]     wr_idx;
    logic [ADDR_W-1:0]     rd_idx;
    logic [LVL_W-1:0]      level;
    logic [RD_LATENCY-1:0] rd_pipe;
    logic [31:0]           inflight;
    logic [31:0]           total_q;
    logic                  underflow_q;
    logic                  rd_req;
    logic                  push;
    logic                  pop;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state <= WAIT_INIT;
        end else begin
            state <= next_state;
        end
    end

    // Reads are only issued while buffered plus in-flight pointers leave room, so the FIFO cannot overflow.
    always_comb begin
        next_state = state;
        rd_req     = 1'b0;
        case (state)
            WAIT_INIT: begin
                if (bus.fl_init_done) begin
                    next_state = RUN;
                end
            end
            RUN: begin
                rd_req = !bus.fl_empty &&
                         ((32'(level) + inflight) < 32'(PREFETCH_DEPTH));
            end
            default: next_state = WAIT_INIT;
        endcase
    end

    always_comb begin
        inflight = '0;
        for (int i = 0; i < RD_LATENCY; i++) begin
            inflight = inflight + 32'(rd_pipe[i]);
        end
    end

    // The flag leaving the last stage marks the cycle fl_rd_dout carries that read's pointer.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            rd_pipe <= '0;
        end else begin
            rd_pipe[0] <= rd_req;
            for (int i = 1; i < RD_LATENCY; i++) begin
                rd_pipe[i] <= rd_pipe[i-1];
            end
        end
    end

    assign push = rd_pipe[RD_LATENCY-1];
    assign pop  = bus.alloc_req && (level != '0);

    always_ff @(posedge clk) begin
        if (rstn && push) begin
            mem[wr_idx] <= bus.fl_rd_dout;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_idx      <= '0;
            rd_idx      <= '0;
            level       <= '0;
            total_q     <= '0;
            underflow_q <= 1'b0;
        end else begin
            if (push) begin
                wr_idx <= wr_idx + ADDR_W'(1);
            end
            if (pop) begin
                rd_idx  <= rd_idx + ADDR_W'(1);
                total_q <= total_q + 32'd1;
            end
            if (push && !pop) begin
                level <= level + LVL_W'(1);
            end else if (pop && !push) begin
                level <= level - LVL_W'(1);
            end
            if (bus.alloc_req && (level == '0)) begin
                underflow_q <= 1'b1;
            end
        end
    end

    assign bus.fl_rd_req       = rd_req;
    assign bus.alloc_valid     = (level != '0);
    assign bus.alloc_ptr       = mem[rd_idx];
    assign bus.alloc_level     = level;
    assign bus.alloc_total     = total_q;
    assign bus.alloc_underflow = underflow_q;
endmodule
